// File: rtl/riscv_regfile_mp_if.sv
// Register-file access bus: read ports, write-back ports, allocation and flush.
// Signal suffixes are seen from the register file (slave) side.
interface riscv_regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs_idx_i;
    logic [NRD*XLEN-1:0] rs_val_o;
    logic [NRD-1:0]      rs_rdy_o;
    logic [NWR-1:0]      rd_we_i;
    logic [NWR*AW-1:0]   rd_idx_i;
    logic [NWR*XLEN-1:0] rd_val_i;
    logic                alloc_valid_i;
    logic [AW-1:0]       alloc_idx_i;
    logic                flush_i;
    logic [NREGS-1:0]    busy_o;

    modport master (
        output rs_idx_i, rd_we_i, rd_idx_i, rd_val_i, alloc_valid_i, alloc_idx_i, flush_i,
        input  rs_val_o, rs_rdy_o, busy_o
    );

    modport slave (
        input  rs_idx_i, rd_we_i, rd_idx_i, rd_val_i, alloc_valid_i, alloc_idx_i, flush_i,
        output rs_val_o, rs_rdy_o, busy_o
    );
endinterface

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard
// and optional same-cycle write-to-read forwarding.
module riscv_regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    riscv_regfile_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic [NWR-1:0]             wr_en;
    logic [NRD*XLEN-1:0]        rs_val;
    logic [NRD-1:0]             rs_rdy;

    // Effective write enables: writes aimed at a hardwired x0 are dropped
    always_comb begin
        wr_en = '0;
        for (int unsigned w = 0; w < NWR; w++) begin
            wr_en[w] = bus.rd_we_i[w] &&
                       !(ZERO_REG && (bus.rd_idx_i[w*AW +: AW] == '0));
        end
    end

    // Next register contents; later ports overwrite earlier ones on a conflict
    always_comb begin
        regs_d = regs_q;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                regs_d[bus.rd_idx_i[w*AW +: AW]] = bus.rd_val_i[w*XLEN +: XLEN];
            end
        end
    end

    // Scoreboard next state: clear on write, then set on alloc, then flush overrides all
    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (bus.rd_we_i[w]) begin
                busy_d[bus.rd_idx_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (bus.alloc_valid_i && !(ZERO_REG && (bus.alloc_idx_i == '0))) begin
            busy_d[bus.alloc_idx_i] = 1'b1;
        end
        if (bus.flush_i) begin
            busy_d = '0;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // Read ports: stored value, optionally replaced by an in-flight write
    always_comb begin
        rs_val = '0;
        rs_rdy = '1;
        for (int unsigned k = 0; k < NRD; k++) begin
            rs_val[k*XLEN +: XLEN] = regs_q[bus.rs_idx_i[k*AW +: AW]];
            rs_rdy[k]              = ~busy_q[bus.rs_idx_i[k*AW +: AW]];
            // Forwarding is held off in reset so reads stay at zero while rst_n is low
            if (BYPASS && rst_n) begin
                for (int unsigned w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (bus.rd_idx_i[w*AW +: AW] == bus.rs_idx_i[k*AW +: AW])) begin
                        rs_val[k*XLEN +: XLEN] = bus.rd_val_i[w*XLEN +: XLEN];
                        rs_rdy[k]              = 1'b1;
                    end
                end
            end
            if (ZERO_REG && (bus.rs_idx_i[k*AW +: AW] == '0)) begin
                rs_val[k*XLEN +: XLEN] = '0;
                rs_rdy[k]              = 1'b1;
            end
        end
    end

    // Register and scoreboard state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign bus.rs_val_o = rs_val;
    assign bus.rs_rdy_o = rs_rdy;
    assign bus.busy_o   = busy_q;
endmodule
